// File: rtl/phase_pkg.sv
// Shared types and defaults for the phase counter and its norm handshake.
package phase_pkg;

    localparam int unsigned C_DEFAULT = 20;

    typedef enum logic [1:0] {IDLE, ARM, RUN} phase_state_t;

endpackage

// File: rtl/phase_if.sv
// Start/ready handshake carrying count/max snapshots from phase_counter to norm.
interface phase_if
    import phase_pkg::*;
#(
    parameter int unsigned C = C_DEFAULT
);

    logic         norm_ready;
    logic         start;
    logic [C-1:0] count;
    logic [C-1:0] max;

    modport master (input norm_ready, output start, output count, output max);
    modport slave  (output norm_ready, input start, input count, input max);

endinterface

// File: rtl/sync_edge.sv
// Two-flop synchronizer followed by a rising-edge detect against a third flop.
module sync_edge (
    input  logic clk,
    input  logic nrst,
    input  logic d,
    output logic rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= d;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise = r_sync & ~r_prev;

endmodule

// File: rtl/phase_counter.sv
// Measures the period of sig_in in clock cycles and hands count/max snapshots
// to the norm normalizer, keeping count < max for a stable period.
module phase_counter
    import phase_pkg::*;
#(
    parameter int unsigned C          = C_DEFAULT,
    parameter int unsigned MIN_PERIOD = 16,
    parameter int unsigned HOLDOFF    = 2
) (
    input  logic    clk,
    input  logic    nrst,
    input  logic    sig_in,
    output logic    valid,
    phase_if.master norm_if
);

    localparam int unsigned   HW       = $clog2(HOLDOFF + 1);
    localparam logic [C-1:0]  CNT_SAT  = {C{1'b1}};
    localparam logic [C:0]    MIN_P    = (C + 1)'(MIN_PERIOD);
    localparam logic [HW-1:0] HOLD_SAT = HW'(HOLDOFF);
    localparam logic [1:0]    S_IDLE   = 2'(IDLE);
    localparam logic [1:0]    S_ARM    = 2'(ARM);
    localparam logic [1:0]    S_RUN    = 2'(RUN);

    logic [1:0]    r_state;
    logic [C-1:0]  r_cnt_live;
    logic [C-1:0]  r_period;
    logic [C-1:0]  r_count;
    logic [C-1:0]  r_max;
    logic [HW-1:0] r_hold;
    logic          r_start;
    logic          r_valid;

    logic          w_rise;
    logic [C:0]    w_cnt_inc;
    logic          w_timeout;
    logic          w_accept;
    logic          w_start;
    logic [C-1:0]  w_snap;

    sync_edge u_sync (
        .clk  (clk),
        .nrst (nrst),
        .d    (sig_in),
        .rise (w_rise)
    );

    // Edge acceptance, timeout and start eligibility; an accepted edge defers start.
    always_comb begin
        w_cnt_inc = {1'b0, r_cnt_live} + (C + 1)'(1);
        w_timeout = (r_state != S_IDLE) && (r_cnt_live == CNT_SAT);
        w_accept  = w_rise && !w_timeout &&
                    ((r_state == S_IDLE) || (w_cnt_inc >= MIN_P));
        w_start   = (r_state == S_RUN) && r_valid && norm_if.norm_ready &&
                    (r_hold >= HOLD_SAT) && !w_accept && !w_timeout;
        w_snap    = (r_cnt_live >= r_period) ? (r_period - C'(1)) : r_cnt_live;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state    <= S_IDLE;
            r_cnt_live <= '0;
            r_period   <= '0;
            r_count    <= '0;
            r_max      <= '0;
            r_hold     <= HOLD_SAT;
            r_start    <= 1'b0;
            r_valid    <= 1'b0;
        end else begin
            r_start <= w_start;
            r_valid <= (r_state == S_RUN) && !w_timeout;

            if (w_start) begin
                r_hold  <= HW'(1);
                r_count <= w_snap;
                r_max   <= r_period;
            end else if (r_hold < HOLD_SAT) begin
                r_hold <= r_hold + HW'(1);
            end

            if (w_accept) begin
                r_cnt_live <= '0;
            end else if (r_cnt_live != CNT_SAT) begin
                r_cnt_live <= r_cnt_live + C'(1);
            end

            // A saturated counter means the input stopped: drop the period estimate.
            if (w_timeout) begin
                r_state  <= S_IDLE;
                r_period <= '0;
            end else if (w_accept) begin
                case (r_state)
                    S_IDLE: r_state <= S_ARM;
                    S_ARM: begin
                        r_state  <= S_RUN;
                        r_period <= w_cnt_inc[C-1:0];
                    end
                    S_RUN:   r_period <= w_cnt_inc[C-1:0];
                    default: r_state  <= S_IDLE;
                endcase
            end
        end
    end

    assign valid         = r_valid;
    assign norm_if.start = r_start;
    assign norm_if.count = r_count;
    assign norm_if.max   = r_max;

endmodule

// File: doc/phase_counter.md
# phase_counter

Upstream feeder for the `norm` normalizer. Measures the period of an external periodic signal in clock cycles and tracks the current phase, a cycle count since the last edge. Hands `count`/`max` snapshots to `norm` through a start/ready handshake, so `norm` always sees `count < max` and returns an 8-bit phase fraction.

## Interface
Parameters:
- `C`, 20: width of the counter, `count` and `max`; must match `norm`'s `C`.
- `MIN_PERIOD`, 16: edges arriving fewer than this many cycles after the last accepted edge are ignored as glitches.
- `HOLDOFF`, 2: minimum cycles from one `start` pulse to the next.

Ports:
- `clk` in 1: system clock; all state on rising edge.
- `nrst` in 1: reset, asynchronous, active-low.
- `sig_in` in 1: asynchronous periodic input; rising edges mark period boundaries.
- `norm_ready` in 1: `norm` idle and able to accept `start`.
- `start` out 1: one-cycle pulse launching a `norm` operation.
- `count` out C: phase snapshot presented to `norm`.
- `max` out C: period snapshot presented to `norm`.
- `valid` out 1: a measured period is held (state RUN).

## Operation
- `sig_in` passes through a 2-flop synchronizer, then a rising-edge detect against a third flop.
- `cnt_live` (C bits):
  - On an accepted edge it loads 0.
  - Otherwise it increments, saturating at 2^C-1.
- Edge acceptance: an edge is accepted iff `cnt_live + 1 >= MIN_PERIOD`.
  - The first edge out of IDLE is always accepted.
  - A rejected edge has no effect.
- `period_r`: loads `cnt_live + 1` on an accepted edge while in ARM or RUN.
- States:
  - IDLE: no period known. An accepted edge moves to ARM.
  - ARM: measuring the first period. An accepted edge loads `period_r` and moves to RUN.
  - RUN: issues `start`. Each accepted edge reloads `period_r`.
  - Any state: `cnt_live` reaching 2^C-1 moves to IDLE, clears `period_r` and `valid`, and leaves `cnt_live` saturated until the next edge.
- `start` rule: asserted in RUN when all three hold:
  - `norm_ready` = 1.
  - At least `HOLDOFF` cycles have elapsed since the last `start`.
  - No accepted edge occurs this cycle.
- Snapshot rule: on the cycle `start` is asserted, `count` ← `cnt_live` and `max` ← `period_r`, using pre-update values. Both hold until the next `start`.
- Guarantee: `count < max` whenever `start` = 1, provided the period is stable.
- Period shrinkage: if `cnt_live >= period_r`, `count` is clamped to `period_r - 1` and `max` is unchanged.
- Simultaneous accepted edge and eligible `start`: the edge wins and `start` is deferred one cycle.

## Timing
- Reset values: `start`=0, `count`=0, `max`=0, `valid`=0, `cnt_live`=0, `period_r`=0, synchronizer flops 0, state IDLE, holdoff counter saturated (start permitted immediately).
- Reset mid-operation: everything returns asynchronously to the reset values; any in-flight `norm` result is the consumer's concern.
- Edge latency: a `sig_in` rise is accepted on the 3rd rising `clk` after it becomes stable.
- `valid` rises the cycle after the ARM→RUN transition.
- Earliest `start`: the cycle after `valid` rises, if `norm_ready` is high.
- `start` is registered: `count`/`max` are valid in the same cycle as `start` and stable afterwards.
- Period measurement: an ideal square input with period P cycles gives `max` = P exactly (no ±1 error).

## Structure
- Shared package `phase_pkg`:
  - `typedef enum logic [1:0] {IDLE, ARM, RUN} phase_state_t`.
  - Localparam `C_DEFAULT = 20`.
- Sub-module `sync_edge`: 2-flop synchronizer plus rising-edge detect. Ports `clk`, `nrst`, `d`, `rise`. Reusable elsewhere in the design.
- Everything else lives in one always_ff state/counter block and one always_comb block for `start` eligibility.

## Test plan
- Reset: hold `nrst`=0 for 2 cycles, toggling `sig_in` -> all outputs 0, state IDLE, no `start`.
- Steady period: `sig_in` edges every 30030 cycles (0x754E), `norm_ready` tied 1 -> `valid`=1 after the 2nd edge, every `start` shows `max`=0x754E and `count` < 0x754E, starts spaced exactly `HOLDOFF`=2 cycles.
- Handshake: `norm_ready` high 1 cycle, then low 19 cycles, repeating -> exactly one `start` per high window, `count`/`max` unchanged between starts.
- Glitch rejection: edge at cycle 0, glitch edge at cycle 5, next edge at cycle 1000 -> `max`=1000, glitch ignored.
- Timeout: with `C`=8, stop `sig_in` after RUN -> `cnt_live` saturates at 255, state IDLE, `valid`=0, no further `start`. A new edge pair re-enters RUN.
- Collision and shrink: accepted edge on the same cycle as an eligible `start` -> `start` deferred one cycle with `count`=0. Drop period 1000→400 -> first `start` after the change has `count` ≤ 999 and `max`=1000, then `max`=400 after the next edge.
